mpsoc_spram_memory: RTL and testbench

MPSOC_SPRAM_MEMORY -- requirements
Module: mpsoc_spram_memory

---
 rtl/mpsoc_spram_memory.sv | 120 ++++++++++++
 tb/tb_mpsoc_spram_memory.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_spram_memory.sv
// Single-port RAM with byte-lane writes, registered read data, an
// out-of-range error flag and a self-clearing INIT sequence after reset.
module mpsoc_spram_memory #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    err_o,
    output logic                    init_done_o
);

    localparam int NR_BYTES     = DATA_WIDTH / 8;
    localparam int LOG_NR_BYTES = (NR_BYTES > 1) ? $clog2(NR_BYTES) : 0;
    localparam int LOG_WORDS    = $clog2(MEM_WORDS);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [0:0]            state_q, state_d;
    logic [LOG_WORDS-1:0]  init_cnt_q, init_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic [LOG_WORDS-1:0]  word_idx;
    logic                  addr_oor;

    logic                  wr_en;
    logic [LOG_WORDS-1:0]  wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NR_BYTES-1:0]   wr_be;

    // Address decode: word index from the address above the byte offset
    always_comb begin
        word_addr = addr_i >> LOG_NR_BYTES;
        word_idx  = addr_i[LOG_NR_BYTES +: LOG_WORDS];
        addr_oor  = (word_addr >= ADDR_WIDTH'(MEM_WORDS));
    end

    // Next-state logic: INIT clears one word per cycle, READY serves requests
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        data_d     = data_q;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = word_idx;
        wr_data    = data_i;
        wr_be      = be_i;

        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_cnt_q;
                wr_data    = '0;
                wr_be      = '1;
                data_d     = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LOG_WORDS'(MEM_WORDS - 1)) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                if (req_i) begin
                    if (addr_oor) begin
                        err_d = 1'b1;
                        if (!we_i) begin
                            data_d = '0;
                        end
                    end else if (we_i) begin
                        wr_en = 1'b1;
                    end else begin
                        data_d = mem[word_idx];
                    end
                end
            end
        endcase
    end

    // Control and output registers, asynchronously reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Array write port; contents are only cleared via INIT, never by reset
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            for (int unsigned i = 0; i < NR_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    assign data_o      = data_q;
    assign err_o       = err_q;
    assign init_done_o = (state_q == ST_READY);

endmodule

// File: tb/tb_mpsoc_spram_memory.sv
// Directed self-checking bench for mpsoc_spram_memory (16 x 64-bit words).
module tb_mpsoc_spram_memory;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] data_i;
    logic [63:0] data_o;
    logic        err_o;
    logic        init_done_o;

    int checks   = 0;
    int failures = 0;
    int n;

    mpsoc_spram_memory #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .MEM_WORDS  (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .err_o       (err_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [63:0] addr,
                         input logic [7:0] be, input logic [63:0] data);
        req_i  = req;
        we_i   = we;
        addr_i = addr;
        be_i   = be;
        data_i = data;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 64'h0, 8'h00, 64'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        chk("rst_data", data_o, 64'h0);
        chk("rst_err", {63'h0, err_o}, 64'h0);
        chk("rst_done", {63'h0, init_done_o}, 64'h0);

        // init latency after reset release, requests ignored meanwhile
        rst_i = 1'b0;
        n = 0;
        while (!init_done_o && n < 100) begin
            drive(1'b1, 1'b0, 64'h80, 8'h00, 64'h0);
            tick();
            n++;
            if (!init_done_o) begin
                chk("init_err", {63'h0, err_o}, 64'h0);
                chk("init_data", data_o, 64'h0);
            end
        end
        chk("init_latency", n, 64'd16);

        // every word cleared
        for (int w = 0; w < 16; w++) begin
            drive(1'b1, 1'b0, 64'(w * 8), 8'h00, 64'h0);
            tick();
            chk($sformatf("clr_rd%0d", w), data_o, 64'h0);
            chk($sformatf("clr_err%0d", w), {63'h0, err_o}, 64'h0);
        end

        // byte-lane merge on word 3
        drive(1'b1, 1'b1, 64'h18, 8'hFF, 64'h1122334455667788);
        tick();
        drive(1'b1, 1'b1, 64'h18, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
        tick();
        drive(1'b1, 1'b0, 64'h18, 8'h00, 64'h0);
        tick();
        chk("be_merge", data_o, 64'h11223344AAAAAAAA);

        // zero byte-enable leaves word unchanged; data_o holds over the write
        drive(1'b1, 1'b1, 64'h18, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        tick();
        chk("hold_after_wr", data_o, 64'h11223344AAAAAAAA);
        drive(1'b1, 1'b0, 64'h1D, 8'h00, 64'h0);
        tick();
        chk("be_zero_offs", data_o, 64'h11223344AAAAAAAA);

        // out-of-range read, then in-range read
        drive(1'b1, 1'b0, 64'h80, 8'h00, 64'h0);
        tick();
        chk("oor_err", {63'h0, err_o}, 64'h1);
        chk("oor_data", data_o, 64'h0);
        drive(1'b1, 1'b0, 64'h18, 8'h00, 64'h0);
        tick();
        chk("oor_clear", {63'h0, err_o}, 64'h0);
        chk("oor_next_rd", data_o, 64'h11223344AAAAAAAA);

        // out-of-range write must not alias onto word 0
        drive(1'b1, 1'b1, 64'h80, 8'hFF, 64'h5555);
        tick();
        chk("oor_wr_err", {63'h0, err_o}, 64'h1);
        chk("oor_wr_hold", data_o, 64'h11223344AAAAAAAA);
        drive(1'b1, 1'b0, 64'h8000000000000000, 8'h00, 64'h0);
        tick();
        chk("oor_hi_err", {63'h0, err_o}, 64'h1);
        drive(1'b1, 1'b0, 64'h00, 8'h00, 64'h0);
        tick();
        chk("oor_wr_noalias", data_o, 64'h0);
        idle();
        tick();
        chk("err_idle", {63'h0, err_o}, 64'h0);

        // write then immediate read, then hold through idle
        drive(1'b1, 1'b1, 64'h08, 8'hFF, 64'hDEAD);
        tick();
        drive(1'b1, 1'b0, 64'h08, 8'h00, 64'h0);
        tick();
        chk("wr_rd_fwd", data_o, 64'hDEAD);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle_hold%0d", i), data_o, 64'hDEAD);
        end

        // reset pulse mid-INIT restarts from word 0
        rst_i = 1'b1;
        tick();
        chk("rst2_data", data_o, 64'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_init_done", {63'h0, init_done_o}, 64'h0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n = 0;
        while (!init_done_o && n < 100) begin
            drive(1'b1, 1'b1, 64'h10, 8'hFF, 64'hBEEF);
            tick();
            n++;
        end
        chk("restart_latency", n, 64'd16);
        drive(1'b1, 1'b0, 64'h10, 8'h00, 64'h0);
        tick();
        chk("init_ignores_wr", data_o, 64'h0);

        // array cleared by INIT after reset in READY
        drive(1'b1, 1'b1, 64'h00, 8'hFF, 64'hFF);
        tick();
        drive(1'b1, 1'b0, 64'h00, 8'h00, 64'h0);
        tick();
        chk("pre_rst_rd", data_o, 64'hFF);
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        n = 0;
        while (!init_done_o && n < 100) begin
            tick();
            n++;
        end
        chk("rst3_latency", n, 64'd16);
        drive(1'b1, 1'b0, 64'h00, 8'h00, 64'h0);
        tick();
        chk("post_rst_w0", data_o, 64'h0);
        drive(1'b1, 1'b0, 64'h18, 8'h00, 64'h0);
        tick();
        chk("post_rst_w3", data_o, 64'h0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
